// File: rtl/baud_pkg.sv
// -----------------------------------------------------------------------------
// baud_pkg
// Shared definitions for the baud-rate generator:
//   - reset-time defaults for clock frequency, baud rate, oversampling and
//     divisor width
//   - the reset divisor computation (integer floor of CLK_HZ/(BAUD*OVERSAMPLE))
//   - parameter legality checks evaluated at elaboration
//   - tick_t, the bundle of one-cycle tick pulses driven by the generator
// No ports (package).
// -----------------------------------------------------------------------------
package baud_pkg;

  localparam int CLK_HZ_DEF = 100_000_000;
  localparam int BAUD_DEF   = 115200;
  localparam int OS_DEF     = 16;
  localparam int CNT_W_DEF  = 16;

  typedef struct packed {
    logic os_tick;
    logic bit_tick;
    logic mid_tick;
  } tick_t;

  // Clock cycles per oversample tick at reset, rounded down.
  function automatic int calc_def_div(input int clk_hz, input int baud, input int os);
    longint prod;
    prod = longint'(baud) * longint'(os);
    if (prod <= 64'sd0) begin
      return 0;
    end else begin
      return int'(longint'(clk_hz) / prod);
    end
  endfunction

  function automatic bit is_pow2_ge4(input int v);
    return (v >= 4) && ((v & (v - 32'sd1)) == 32'sd0);
  endfunction

  // True when value d is representable in an unsigned field of w bits.
  function automatic bit fits_width(input int d, input int w);
    if (w >= 31) begin
      return 1'b1;
    end else begin
      return (d >= 0) && (d < (32'sd1 <<< w));
    end
  endfunction

  function automatic bit params_ok(input int clk_hz, input int baud, input int os, input int cnt_w);
    int d;
    d = calc_def_div(clk_hz, baud, os);
    return is_pow2_ge4(os) && (d >= 2) && fits_width(d, cnt_w);
  endfunction

endpackage

// File: rtl/baud_gen_if.sv
// -----------------------------------------------------------------------------
// baud_gen_if
// Control and tick bundle between a baud generator and its user.
//   en        count enable
//   sync      phase restart pulse (e.g. RX start edge)
//   div_load  load div_in as the new divisor
//   div_in    clock cycles per oversample tick (CNT_W bits)
//   os_tick   one-cycle pulse per oversample period
//   bit_tick  one-cycle pulse per bit period
//   mid_tick  one-cycle pulse at bit centre
//   clk_out   50% square wave at the baud rate
//   div_err   one-cycle pulse when a divisor load is rejected
// Modports: master drives the controls, slave (the generator) drives ticks.
// -----------------------------------------------------------------------------
interface baud_gen_if import baud_pkg::*; #(
  parameter int CNT_W = CNT_W_DEF
) ();

  logic             en;
  logic             sync;
  logic             div_load;
  logic [CNT_W-1:0] div_in;
  logic             os_tick;
  logic             bit_tick;
  logic             mid_tick;
  logic             clk_out;
  logic             div_err;

  modport master (
    output en, sync, div_load, div_in,
    input  os_tick, bit_tick, mid_tick, clk_out, div_err
  );

  modport slave (
    input  en, sync, div_load, div_in,
    output os_tick, bit_tick, mid_tick, clk_out, div_err
  );

endinterface

// File: rtl/baud_gen_mod_cnt.sv
// -----------------------------------------------------------------------------
// mod_cnt
// Wrapping modulo counter: counts 0..max_i while enabled, then returns to 0.
//   clk     rising-edge clock
//   rst     synchronous active-high reset (count -> 0)
//   clr_i   synchronous clear; wins over enable and suppresses the wrap pulse
//   en_i    advance enable
//   max_i   terminal count (modulus - 1)
//   cnt_o   current count
//   wrap_o  combinational pulse in the cycle the count returns to 0
// -----------------------------------------------------------------------------
module mod_cnt #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr_i,
  input  logic         en_i,
  input  logic [W-1:0] max_i,
  output logic [W-1:0] cnt_o,
  output logic         wrap_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;
  logic         wrap;

  // Next count: clear first, then wrap at the terminal value, else increment.
  always_comb begin
    cnt_d = cnt_q;
    wrap  = 1'b0;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      // >= rather than == so a count stranded above max still recovers.
      if (cnt_q >= max_i) begin
        cnt_d = '0;
        wrap  = 1'b1;
      end else begin
        cnt_d = cnt_q + W'(1);
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign wrap_o = wrap;

endmodule

// File: rtl/baud_gen.sv
// -----------------------------------------------------------------------------
// baud_gen
// Programmable baud-rate generator with oversample, bit and bit-centre ticks.
// A fast counter divides clk by the divisor to make os_tick; a slow counter
// divides os_tick by OVERSAMPLE to make bit_tick and mid_tick. clk_out toggles
// on every mid_tick and bit_tick, so it is low for the first half of a bit.
//   clk   rising-edge clock
//   rst   synchronous active-high reset, highest priority
//   bus   baud_gen_if.slave: en, sync, div_load, div_in in;
//         os_tick, bit_tick, mid_tick, clk_out, div_err out (all registered)
// -----------------------------------------------------------------------------
module baud_gen import baud_pkg::*; #(
  parameter int CLK_HZ     = CLK_HZ_DEF,
  parameter int BAUD       = BAUD_DEF,
  parameter int OVERSAMPLE = OS_DEF,
  parameter int CNT_W      = CNT_W_DEF
) (
  input  logic       clk,
  input  logic       rst,
  baud_gen_if.slave  bus
);

  localparam int DEF_DIV = calc_def_div(CLK_HZ, BAUD, OVERSAMPLE);
  localparam int OS_W    = $clog2(OVERSAMPLE);

  localparam logic [CNT_W-1:0] DIV_RST    = CNT_W'(DEF_DIV);
  localparam logic [OS_W-1:0]  OS_LAST    = OS_W'(OVERSAMPLE - 1);
  // os_cnt value whose wrap lands on OVERSAMPLE/2, i.e. the bit centre.
  localparam logic [OS_W-1:0]  OS_PRE_MID = OS_W'(OVERSAMPLE / 2 - 1);

  if (!params_ok(CLK_HZ, BAUD, OVERSAMPLE, CNT_W)) begin : g_bad_params
    $fatal(1, "baud_gen: DEF_DIV < 2, DEF_DIV exceeds CNT_W, or OVERSAMPLE not a power of two >= 4");
  end

  logic [CNT_W-1:0] div_q;
  logic [CNT_W-1:0] div_d;
  logic [CNT_W-1:0] cnt_max;
  logic [CNT_W-1:0] cnt_unused;
  logic [OS_W-1:0]  os_cnt;
  logic             cnt_wrap;
  logic             os_wrap;
  logic             load_ok;
  logic             load_bad;
  logic             cnt_clr;
  tick_t            tick_q;
  tick_t            tick_d;
  logic             clk_out_q;
  logic             clk_out_d;
  logic             div_err_q;
  logic             div_err_d;

  // A divisor below 2 cannot produce a distinct tick period and is refused.
  assign load_ok  = bus.div_load && (bus.div_in >= CNT_W'(2));
  assign load_bad = bus.div_load && (bus.div_in <  CNT_W'(2));
  assign cnt_max  = div_q - CNT_W'(1);
  // Restarting the fast count on a load drops any wrap due this cycle.
  assign cnt_clr  = bus.sync || load_ok;

  mod_cnt #(.W(CNT_W)) u_fast_cnt (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (cnt_clr),
    .en_i   (bus.en),
    .max_i  (cnt_max),
    .cnt_o  (cnt_unused),
    .wrap_o (cnt_wrap)
  );

  // Only sync restarts the bit phase; a divisor load keeps it.
  mod_cnt #(.W(OS_W)) u_os_cnt (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (bus.sync),
    .en_i   (cnt_wrap),
    .max_i  (OS_LAST),
    .cnt_o  (os_cnt),
    .wrap_o (os_wrap)
  );

  // Next-state for divisor, tick pulses, baud clock and load error.
  always_comb begin
    div_d     = div_q;
    tick_d    = '0;
    clk_out_d = clk_out_q;
    div_err_d = 1'b0;

    if (load_ok) begin
      div_d = bus.div_in;
    end else begin
      div_d = div_q;
    end

    // cnt_wrap is already gated by en, sync and load, so ticks inherit that.
    tick_d.os_tick  = cnt_wrap;
    tick_d.bit_tick = os_wrap;
    tick_d.mid_tick = cnt_wrap && (os_cnt == OS_PRE_MID);

    if (bus.sync) begin
      clk_out_d = 1'b0;
    end else if (tick_d.bit_tick || tick_d.mid_tick) begin
      clk_out_d = ~clk_out_q;
    end else begin
      clk_out_d = clk_out_q;
    end

    div_err_d = load_bad;
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_q     <= DIV_RST;
      tick_q    <= '0;
      clk_out_q <= 1'b0;
      div_err_q <= 1'b0;
    end else begin
      div_q     <= div_d;
      tick_q    <= tick_d;
      clk_out_q <= clk_out_d;
      div_err_q <= div_err_d;
    end
  end

  assign bus.os_tick  = tick_q.os_tick;
  assign bus.bit_tick = tick_q.bit_tick;
  assign bus.mid_tick = tick_q.mid_tick;
  assign bus.clk_out  = clk_out_q;
  assign bus.div_err  = div_err_q;

endmodule

// File: tb/tb_baud_gen.sv
// -----------------------------------------------------------------------------
// tb_baud_gen
// Scoreboard bench for baud_gen at default parameters (reset divisor 54,
// oversample 16). Stimulus pushes expected output events {cycle, os, bit,
// mid, err, clk_out}; a monitor compares them whenever the DUT shows a tick,
// an error pulse or a clk_out change, or an expected event's cycle arrives.
// Cycle n is the interval after the n-th rising edge. Tick timing counts
// from the first cycle in which the fast counter is 0 and enabled.
// -----------------------------------------------------------------------------
module tb_baud_gen;

  localparam int OS = 16;

  typedef struct {
    int cyc;
    bit os;
    bit bt;
    bit md;
    bit er;
    bit ck;
  } ev_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  bit   track = 1'b0;
  bit   flush = 1'b0;
  int   n_pass = 0;
  int   n_total = 0;
  ev_t  q[$];

  baud_gen_if #(.CNT_W(16)) bus_if ();

  baud_gen dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  always #5 clk = ~clk;

  // Cycle index, advanced on every rising edge.
  always @(posedge clk) cyc <= cyc + 1;

  // Insert an expected event keeping the queue in cycle order.
  task automatic push_ev(input int c, input bit os, input bit bt, input bit md,
                         input bit er, input bit ck);
    ev_t e;
    int  i;
    e.cyc = c; e.os = os; e.bt = bt; e.md = md; e.er = er; e.ck = ck;
    i = 0;
    while (i < q.size() && q[i].cyc <= c) i++;
    q.insert(i, e);
  endtask

  // n os_ticks, every d cycles after t0 (cycle where cnt=0 and counting),
  // starting from slow-count phase ph0 and clk_out level ck0.
  task automatic expect_ticks(input int t0, input int d, input int ph0, input bit ck0,
                              input int n, output bit ck_end);
    bit ck;
    int ph;
    ck = ck0;
    for (int k = 1; k <= n; k++) begin
      ph = (ph0 + k) % OS;
      if (ph == 0 || ph == OS / 2) ck = ~ck;
      push_ev(t0 + k * d, 1'b1, ph == 0, ph == OS / 2, 1'b0, ck);
    end
    ck_end = ck;
  endtask

  task automatic wait_cyc(input int target);
    while (cyc < target) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor: pops and compares whenever the DUT presents output activity.
  initial begin : monitor
    ev_t fe;
    bit  ck_prev;
    bit  act;
    ck_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (flush) begin
        while (q.size() > 0) begin
          fe = q.pop_front();
          n_total++;
          $display("FAIL missing_event: expected event at cycle %0d never checked", fe.cyc);
        end
      end else if (track) begin
        while (q.size() > 0 && q[0].cyc < cyc) begin
          fe = q.pop_front();
          n_total++;
          $display("FAIL missed_event: expected event at cycle %0d not seen (now %0d)", fe.cyc, cyc);
        end
        act = bus_if.os_tick || bus_if.bit_tick || bus_if.mid_tick || bus_if.div_err ||
              (bus_if.clk_out !== ck_prev);
        if (q.size() > 0 && q[0].cyc == cyc) begin
          fe = q.pop_front();
          n_total++;
          if ({bus_if.os_tick, bus_if.bit_tick, bus_if.mid_tick, bus_if.div_err, bus_if.clk_out}
              === {fe.os, fe.bt, fe.md, fe.er, fe.ck}) begin
            n_pass++;
          end else begin
            $display("FAIL event@%0d: got os=%b bit=%b mid=%b err=%b clk_out=%b, required os=%b bit=%b mid=%b err=%b clk_out=%b",
                     cyc, bus_if.os_tick, bus_if.bit_tick, bus_if.mid_tick, bus_if.div_err,
                     bus_if.clk_out, fe.os, fe.bt, fe.md, fe.er, fe.ck);
          end
        end else if (act) begin
          n_total++;
          $display("FAIL unexpected@%0d: got os=%b bit=%b mid=%b err=%b clk_out=%b, required no activity",
                   cyc, bus_if.os_tick, bus_if.bit_tick, bus_if.mid_tick, bus_if.div_err, bus_if.clk_out);
        end
      end
      ck_prev = bus_if.clk_out;
    end
  end

  // Stimulus: directed phases, each pushing its hand-computed expectations.
  initial begin : stimulus
    int R, L, S, T, E, Q, R3;
    bit ck;
    bus_if.en       = 1'b0;
    bus_if.sync     = 1'b0;
    bus_if.div_load = 1'b0;
    bus_if.div_in   = 16'd0;
    rst             = 1'b1;
    @(posedge clk);
    #1;
    track = 1'b1;

    // Reset state: every output low while rst is held.
    push_ev(cyc + 1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    push_ev(cyc + 2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Default divisor 54: os every 54, mid at 432, bit at 864.
    wait_cyc(4);
    R = cyc;
    rst = 1'b0;
    bus_if.en = 1'b1;
    expect_ticks(R, 54, 0, 1'b0, 24, ck);

    // Rejected loads (1 then 0): one err pulse each, timing untouched.
    wait_cyc(R + 1000);
    bus_if.div_load = 1'b1; bus_if.div_in = 16'd1;
    push_ev(R + 1001, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    @(posedge clk); #1;
    bus_if.div_load = 1'b0;
    wait_cyc(R + 1010);
    bus_if.div_load = 1'b1; bus_if.div_in = 16'd0;
    push_ev(R + 1011, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    @(posedge clk); #1;
    bus_if.div_load = 1'b0;

    // Load divisor 4 mid-period: phase 8 and clk_out=1 kept, cnt restarts.
    wait_cyc(R + 1310);
    L = cyc;
    bus_if.div_load = 1'b1; bus_if.div_in = 16'd4;
    expect_ticks(L + 1, 4, 8, ck, 52, ck);
    @(posedge clk); #1;
    bus_if.div_load = 1'b0;

    // Sync while clk_out=1 and a wrap is due (cnt=3): no tick next cycle,
    // clk_out drops, mid 32 and bit 64 cycles into the restarted bit.
    S = L + 212;
    wait_cyc(S);
    bus_if.sync = 1'b1;
    push_ev(S + 1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    expect_ticks(S + 1, 4, 0, 1'b0, 16, ck);
    @(posedge clk); #1;
    bus_if.sync = 1'b0;

    // Sync together with a load of 6: both apply.
    T = S + 66;
    wait_cyc(T);
    bus_if.sync = 1'b1; bus_if.div_load = 1'b1; bus_if.div_in = 16'd6;
    expect_ticks(T + 1, 6, 0, ck, 8, ck);
    @(posedge clk); #1;
    bus_if.sync = 1'b0; bus_if.div_load = 1'b0;

    // en low for 100 cycles with cnt=2: everything freezes, then resumes.
    E = T + 51;
    wait_cyc(E);
    bus_if.en = 1'b0;
    wait_cyc(E + 100);
    bus_if.en = 1'b1;
    expect_ticks(E + 98, 6, 8, ck, 16, ck);

    // rst mid-period with clk_out=1 and divisor 6: outputs clear, divisor
    // returns to 54 and start-up timing repeats.
    Q = E + 196;
    wait_cyc(Q);
    rst = 1'b1;
    push_ev(Q + 1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    push_ev(Q + 2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    wait_cyc(Q + 2);
    R3 = cyc;
    rst = 1'b0;
    expect_ticks(R3, 54, 0, 1'b0, 8, ck);

    wait_cyc(R3 + 440);
    flush = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/baud_gen.md
BAUD_GEN -- requirements
Module: baud_gen

Interface
REQ-001 Parameter CLK_HZ, default 100_000_000, input clock frequency in Hz.
REQ-002 Parameter BAUD, default 115200, reset-time baud rate.
REQ-003 Parameter OVERSAMPLE, default 16, oversample ticks per bit; power of two, >=4.
REQ-004 Parameter CNT_W, default 16, divisor/counter width.
REQ-005 Ports:
- clk  in  1  sole clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- en  in  1  count enable.
- sync  in  1  phase restart pulse, e.g. on an RX start edge.
- div_load  in  1  load div_in as the new divisor.
- div_in  in  CNT_W  clk cycles per oversample tick.
- os_tick  out  1  one-cycle pulse per oversample period.
- bit_tick  out  1  one-cycle pulse per bit period.
- mid_tick  out  1  one-cycle pulse at bit centre.
- clk_out  out  1  50% square wave at the baud rate.
- div_err  out  1  one-cycle pulse when a load is rejected.

Function
REQ-006 Divisor register div resets to DEF_DIV = CLK_HZ/(BAUD*OVERSAMPLE), integer floor (54 at defaults).
REQ-007 Fast counter cnt counts 0..div-1 while en=1, then wraps to 0; it holds when en=0.
REQ-008 os_tick is registered and asserts in the cycle after cnt wraps, giving a period of exactly div cycles.
REQ-009 First os_tick occurs div cycles after the first cycle en is sampled high, counted from cnt=0.
REQ-010 Slow counter os_cnt (0..OVERSAMPLE-1) increments on each cnt wrap and wraps to 0.
REQ-011 bit_tick is coincident with the os_tick whose wrap takes os_cnt to 0, giving a period of div*OVERSAMPLE cycles.
REQ-012 mid_tick is coincident with the os_tick whose wrap takes os_cnt to OVERSAMPLE/2.
REQ-013 clk_out toggles in the same cycle as each mid_tick and each bit_tick; it is low in the first half of each bit period measured from sync.
REQ-014 sync is honoured regardless of en:
- next cycle: cnt=0, os_cnt=0, clk_out=0.
- any tick due in that cycle is suppressed.
- first mid_tick falls div*OVERSAMPLE/2 cycles after sync (with en=1).
REQ-015 div_load with div_in>=2:
- next cycle: div=div_in and cnt=0.
- os_cnt and clk_out are unchanged.
- any os_tick due in that cycle is suppressed.
REQ-016 div_load with div_in<2 leaves div and cnt unchanged and pulses div_err for one cycle.
REQ-017 sync and div_load in the same cycle: both take effect (REQ-014 and REQ-015 combined).
REQ-018 en deasserted mid-period: counters and clk_out freeze and no ticks are emitted; counting resumes from the held state.
REQ-019 At most one of bit_tick and mid_tick is asserted in any cycle; neither asserts without os_tick.
REQ-020 Elaboration fails if DEF_DIV<2, if DEF_DIV does not fit CNT_W, or if OVERSAMPLE is not a power of two >=4.

Reset
REQ-021 rst has priority over sync, div_load and en.
REQ-022 On rst: div=DEF_DIV, cnt=0, os_cnt=0, and all outputs (os_tick, bit_tick, mid_tick, clk_out, div_err) are 0.
REQ-023 rst asserted mid-period discards the partial period; the first os_tick after release follows REQ-009.

Structure
REQ-024 Shared package baud_pkg holds the CLK_HZ/BAUD defaults, the DEF_DIV computation and the parameter legality checks.
REQ-025 One sub-module, mod_cnt (wrapping modulo counter with clear, enable and wrap pulse), is instantiated twice: once for cnt, once for os_cnt.

Verification
REQ-026 Defaults, en=1 from reset release -> os_tick every 54 cycles, bit_tick every 864, clk_out high 432 / low 432.
REQ-027 div_load div_in=4, en=1 -> os_tick every 4 cycles, bit_tick every 64, mid_tick 32 cycles after each bit_tick.
REQ-028 div=4 steady state, sync pulse mid-bit -> clk_out=0 next cycle, mid_tick exactly 32 cycles after sync, bit_tick 64 after sync, no tick in the sync cycle.
REQ-029 div_load div_in=1, then div_in=0 -> one div_err pulse per load, os_tick period unchanged.
REQ-030 en low for 100 cycles mid-period, and separately rst mid-period -> en: no ticks, cnt/os_cnt/clk_out frozen, original phase resumes on en high; rst: all outputs 0, div=54, REQ-026 timing restarts.
